parameterized_counter_checker: RTL and testbench

PARAMETERIZED_COUNTER_CHECKER -- requirements
Module: parameterized_counter_checker

---
 rtl/parameterized_counter_checker.sv | 85 ++++++++
 tb/tb_parameterized_counter_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parameterized_counter_checker.sv
// Watches a free-running counter, classifies each sampled step (hold/up/down/jump)
// and flags jumps that arrive while a counting direction is established.
module parameterized_counter_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             load_hint,
  output logic [1:0]       dir,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_value
);

  typedef enum logic [1:0] {EMPTY, ACQUIRE, TRACK_UP, TRACK_DOWN} state_t;

  localparam logic [1:0] D_HOLD = 2'b00;
  localparam logic [1:0] D_UP   = 2'b01;
  localparam logic [1:0] D_DOWN = 2'b10;
  localparam logic [1:0] D_JUMP = 2'b11;

  state_t           state;
  logic [1:0]       step;
  logic [WIDTH-1:0] nxt_up, nxt_dn;

  // Modulo-2^WIDTH neighbours, so wrap-around is an ordinary step.
  // Up is tested before down: at WIDTH=1 both neighbours coincide.
  assign nxt_up = last_value + WIDTH'(1);
  assign nxt_dn = last_value - WIDTH'(1);

  always_comb begin
    step = D_JUMP;
    if (count_in == last_value)  step = D_HOLD;
    else if (count_in == nxt_up) step = D_UP;
    else if (count_in == nxt_dn) step = D_DOWN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      dir        <= D_HOLD;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
      last_value <= '0;
    end else begin
      step_err <= 1'b0;
      if (sample_en) begin
        last_value <= count_in;
        if (state == EMPTY) begin
          dir    <= D_JUMP;
          state  <= ACQUIRE;
          locked <= 1'b0;
        end else begin
          dir <= step;
          case (step)
            D_UP: begin
              state  <= TRACK_UP;
              locked <= 1'b1;
            end
            D_DOWN: begin
              state  <= TRACK_DOWN;
              locked <= 1'b1;
            end
            D_JUMP: begin
              state  <= ACQUIRE;
              locked <= 1'b0;
              // Only an unannounced jump out of a tracked direction is illegal.
              if (!load_hint && (state == TRACK_UP || state == TRACK_DOWN)) begin
                step_err <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_parameterized_counter_checker.sv
// Scoreboard bench: a reference model predicts outputs for each driven cycle,
// predictions are queued and compared one cycle later against two DUT instances.
module tb_parameterized_counter_checker;

  logic       clk = 1'b0;
  logic       reset, sample_en, load_hint;
  logic [3:0] count_in;

  logic [1:0] dir, dir2;
  logic       locked, locked2, step_err, step_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [3:0] last_value, last_value2;

  always #5 clk = ~clk;

  parameterized_counter_checker #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .load_hint(load_hint), .dir(dir), .locked(locked), .step_err(step_err),
    .err_count(err_count), .last_value(last_value));

  parameterized_counter_checker #(.WIDTH(4), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .load_hint(load_hint), .dir(dir2), .locked(locked2), .step_err(step_err2),
    .err_count(err_count2), .last_value(last_value2));

  typedef struct packed {
    logic [1:0] dir;
    logic       locked;
    logic       step_err;
    logic [7:0] err;
    logic [1:0] err2;
    logic [3:0] last;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // model state: 0 empty, 1 acquire, 2 track up, 3 track down
  int         m_st = 0;
  exp_t       m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic predict(input logic en, input logic [3:0] v, input logic h, input logic r);
    logic [3:0] up, dn;
    up = m.last + 4'd1;
    dn = m.last - 4'd1;
    m.step_err = 1'b0;
    if (r) begin
      m = '0;
      m_st = 0;
    end else if (en) begin
      if (m_st == 0) begin
        m.dir = 2'b11;
        m_st = 1;
      end else if (v == m.last) begin
        m.dir = 2'b00;
      end else if (v == up) begin
        m.dir = 2'b01;
        m_st = 2;
      end else if (v == dn) begin
        m.dir = 2'b10;
        m_st = 3;
      end else begin
        m.dir = 2'b11;
        if (!h && m_st >= 2) begin
          m.step_err = 1'b1;
          if (m.err != 8'hff) m.err++;
          if (m.err2 != 2'd3) m.err2++;
        end
        m_st = 1;
      end
      m.locked = (m_st >= 2);
      m.last = v;
    end
    q.push_back(m);
  endtask

  task automatic step(input logic en, input logic [3:0] v, input logic h, input logic r);
    exp_t e;
    @(negedge clk);
    sample_en = en; count_in = v; load_hint = h; reset = r;
    predict(en, v, h, r);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("dir",        dir,        e.dir);
    chk("locked",     locked,     e.locked);
    chk("step_err",   step_err,   e.step_err);
    chk("err_count",  err_count,  e.err);
    chk("last_value", last_value, e.last);
    chk("sat_err_count", err_count2, e.err2);
    chk("sat_step_err",  step_err2,  e.step_err);
  endtask

  task automatic smp(input logic [3:0] v, input logic h = 1'b0);
    step(1'b1, v, h, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; count_in = '0; load_hint = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("reset_dir", dir, 2'b00);
    chk("reset_last", last_value, 4'd0);

    // acquire
    smp(4'd3);
    chk("acq_first_dir", dir, 2'b11);
    smp(4'd4);
    chk("acq_dir", dir, 2'b01);
    chk("acq_locked", locked, 1'b1);
    smp(4'd5);
    chk("acq_no_err", step_err, 1'b0);

    // wrap up then down
    smp(4'd14, 1'b1);
    smp(4'd15);
    smp(4'd0);
    chk("wrap_up_dir", dir, 2'b01);
    chk("wrap_up_err", step_err, 1'b0);
    smp(4'd1);
    smp(4'd0);
    smp(4'd15);
    chk("wrap_dn_dir", dir, 2'b10);
    chk("wrap_dn_locked", locked, 1'b1);

    // illegal jump
    smp(4'd5, 1'b1);
    smp(4'd6);
    smp(4'd9);
    chk("jump_err", step_err, 1'b1);
    chk("jump_cnt", err_count, 8'd1);
    chk("jump_locked", locked, 1'b0);
    chk("jump_dir", dir, 2'b11);
    chk("jump_last", last_value, 4'd9);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("jump_pulse_end", step_err, 1'b0);

    // legal reload
    smp(4'd6, 1'b1);
    smp(4'd5);
    chk("reload_track_dn", dir, 2'b10);
    smp(4'd0, 1'b1);
    chk("reload_no_err", step_err, 1'b0);
    chk("reload_cnt", err_count, 8'd1);
    chk("reload_unlocked", locked, 1'b0);
    smp(4'd1);
    chk("reload_up", dir, 2'b01);

    // gap then hold
    smp(4'd6, 1'b1);
    smp(4'd7);
    for (int i = 0; i < 5; i++) step(1'b0, 4'($urandom_range(15)), 1'b1, 1'b0);
    chk("gap_frozen", last_value, 4'd7);
    smp(4'd8);
    chk("gap_dir", dir, 2'b01);
    smp(4'd8);
    chk("hold_dir", dir, 2'b00);
    chk("hold_locked", locked, 1'b1);

    // saturation on the narrow counter
    step(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      smp(4'd2);
      smp(4'd3);
      smp(4'd10);
      chk("sat_pulse", step_err2, 1'b1);
    end
    chk("sat_value", err_count2, 2'd3);
    chk("wide_value", err_count, 8'd4);

    // reset wins over a coincident sample; next sample is a first sample
    smp(4'd11);
    step(1'b1, 4'd5, 1'b0, 1'b1);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_last", last_value, 4'd0);
    chk("rst_locked", locked, 1'b0);
    smp(4'd9);
    chk("post_rst_dir", dir, 2'b11);
    chk("post_rst_err", step_err, 1'b0);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
